// File: rtl/axis_deheaderizer.sv
// ---------------------------------------------------------------------------
// axis_deheaderizer
//
// Receive-side header stripper. Each incoming packet is one header flit
// followed by one or more data flits. The header carries
// {pad, first_last, TDEST, TID, TUSER} packed from bit 0 upwards. The block
// removes that header flit and forwards the data flits. Each data flit gets
// the recovered TDEST/TID/TUSER attached as sidechannels. Output flits pass
// through a 2-entry skid buffer, so every sides_* output comes straight from
// a register.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous reset, active low
//   hdr_TDATA_i    headered stream data
//   hdr_TKEEP_i    byte enables (ignored on the header flit)
//   hdr_TLAST_i    end of packet
//   hdr_TVALID_i   input valid
//   hdr_TREADY_o   input ready
//   sides_TDATA_o  payload data
//   sides_TKEEP_o  payload byte enables
//   sides_TLAST_o  payload last
//   sides_TDEST_o  recovered destination
//   sides_TID_o    recovered id
//   sides_TUSER_o  recovered user bits
//   sides_TVALID_o output valid
//   sides_TREADY_i output ready
//   err_o          one-cycle pulse for a malformed header or packet
// ---------------------------------------------------------------------------
module axis_deheaderizer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int USER_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_WIDTH-1:0]   hdr_TDATA_i,
    input  logic [DATA_WIDTH/8-1:0] hdr_TKEEP_i,
    input  logic                    hdr_TLAST_i,
    input  logic                    hdr_TVALID_i,
    output logic                    hdr_TREADY_o,
    output logic [DATA_WIDTH-1:0]   sides_TDATA_o,
    output logic [DATA_WIDTH/8-1:0] sides_TKEEP_o,
    output logic                    sides_TLAST_o,
    output logic [DEST_WIDTH-1:0]   sides_TDEST_o,
    output logic [ID_WIDTH-1:0]     sides_TID_o,
    output logic [USER_WIDTH-1:0]   sides_TUSER_o,
    output logic                    sides_TVALID_o,
    input  logic                    sides_TREADY_i,
    output logic                    err_o
);

    localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
    localparam int HDR_BITS    = 1 + DEST_WIDTH + ID_WIDTH + USER_WIDTH;
    localparam int FL_BIT      = USER_WIDTH + ID_WIDTH + DEST_WIDTH;
    localparam int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + DEST_WIDTH + ID_WIDTH + USER_WIDTH;

    typedef enum logic {
        WAIT_HDR,
        PASS
    } state_t;

    state_t                 state_q;
    logic                   readyEn_q;
    logic [DEST_WIDTH-1:0]  dest_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [USER_WIDTH-1:0]  user_q;
    logic                   firstLast_q;
    logic                   firstPending_q;
    logic                   err_q;

    logic [ENTRY_WIDTH-1:0] out_q;
    logic                   outValid_q;
    logic [ENTRY_WIDTH-1:0] skid_q;
    logic                   skidValid_q;

    logic                   handshake;
    logic                   push;
    logic                   pop;
    logic [DATA_WIDTH-1:0]  padBits;
    logic [ENTRY_WIDTH-1:0] inEntry;

    // Ready depends only on registers. The skid slot being occupied means
    // both entries are full. A pop in that same cycle does not reopen the
    // input until the next cycle. readyEn_q keeps the input closed during
    // reset and for the cycle of release.
    assign hdr_TREADY_o = readyEn_q & ((state_q == WAIT_HDR) | ~skidValid_q);
    assign handshake    = hdr_TVALID_i & hdr_TREADY_o;
    assign push         = handshake & (state_q == PASS);
    assign pop          = outValid_q & sides_TREADY_i;

    // Everything above first_last is pad. An empty pad field shifts to zero.
    assign padBits = hdr_TDATA_i >> HDR_BITS;
    assign inEntry = {hdr_TDATA_i, hdr_TKEEP_i, hdr_TLAST_i, dest_q, id_q, user_q};

    assign {sides_TDATA_o, sides_TKEEP_o, sides_TLAST_o,
            sides_TDEST_o, sides_TID_o, sides_TUSER_o} = out_q;
    assign sides_TVALID_o = outValid_q;
    assign err_o          = err_q;

    // Packet framing FSM. A header handshake latches the sidechannels and
    // flags the header errors (nonzero pad, TLAST on the header). The first
    // data flit is then compared against the latched first_last bit. The
    // error flag is a one-cycle registered pulse and never stalls data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= WAIT_HDR;
            readyEn_q      <= 1'b0;
            dest_q         <= '0;
            id_q           <= '0;
            user_q         <= '0;
            firstLast_q    <= 1'b0;
            firstPending_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            readyEn_q <= 1'b1;
            err_q     <= 1'b0;
            if (handshake) begin
                case (state_q)
                    WAIT_HDR: begin
                        user_q         <= hdr_TDATA_i[USER_WIDTH-1:0];
                        id_q           <= hdr_TDATA_i[USER_WIDTH+ID_WIDTH-1:USER_WIDTH];
                        dest_q         <= hdr_TDATA_i[FL_BIT-1:USER_WIDTH+ID_WIDTH];
                        firstLast_q    <= hdr_TDATA_i[FL_BIT];
                        firstPending_q <= 1'b1;
                        err_q          <= (padBits != '0) | hdr_TLAST_i;
                        state_q        <= PASS;
                    end
                    PASS: begin
                        if (firstPending_q) begin
                            err_q          <= (hdr_TLAST_i != firstLast_q);
                            firstPending_q <= 1'b0;
                        end
                        if (hdr_TLAST_i) begin
                            state_q <= WAIT_HDR;
                        end
                    end
                    default: state_q <= WAIT_HDR;
                endcase
            end
        end
    end

    // Two-entry skid buffer. out_q feeds the outputs directly. skid_q holds
    // a second flit that arrived while out_q was stalled. When out_q frees
    // up, it refills from the skid slot first, so order is preserved. Each
    // entry carries its own sidechannels, so a new header can be latched
    // while older flits are still queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= '0;
            outValid_q  <= 1'b0;
            skid_q      <= '0;
            skidValid_q <= 1'b0;
        end else if (!outValid_q || pop) begin
            if (skidValid_q) begin
                out_q       <= skid_q;
                outValid_q  <= 1'b1;
                skidValid_q <= push;
                if (push) begin
                    skid_q <= inEntry;
                end
            end else begin
                outValid_q <= push;
                if (push) begin
                    out_q <= inEntry;
                end
            end
        end else if (push) begin
            skid_q      <= inEntry;
            skidValid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_deheaderizer.sv
// ---------------------------------------------------------------------------
// tb_axis_deheaderizer
//
// Self-checking bench for axis_deheaderizer (64-bit data, 16/16/8
// sidechannels). Packets are described as header fields plus a data-flit
// count. The reference model turns each one into the expected output flits
// and the expected number of err pulses. A monitor compares every output
// handshake against that queue. It also checks that a stalled output holds
// steady until it is accepted.
// ---------------------------------------------------------------------------
module tb_axis_deheaderizer;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] dest;
        logic [15:0] id;
        logic [7:0]  user;
    } flit_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] hdr_TDATA;
    logic [7:0]  hdr_TKEEP;
    logic        hdr_TLAST;
    logic        hdr_TVALID;
    logic        hdr_TREADY;
    logic [63:0] sides_TDATA;
    logic [7:0]  sides_TKEEP;
    logic        sides_TLAST;
    logic [15:0] sides_TDEST;
    logic [15:0] sides_TID;
    logic [7:0]  sides_TUSER;
    logic        sides_TVALID;
    logic        sides_TREADY;
    logic        err;

    int    assertCount = 0;
    int    failCount   = 0;
    int    errSeen     = 0;
    int    expErr      = 0;
    int    rdyMode     = 0;
    int    patIdx      = 0;
    bit    randValid   = 0;
    bit    checkReadyEn = 0;
    bit    inData      = 0;
    bit    stallPrev   = 0;
    flit_t heldOut;
    flit_t curOut;
    flit_t expQ[$];

    axis_deheaderizer #(
        .DATA_WIDTH(64),
        .DEST_WIDTH(16),
        .ID_WIDTH  (16),
        .USER_WIDTH(8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .hdr_TDATA_i   (hdr_TDATA),
        .hdr_TKEEP_i   (hdr_TKEEP),
        .hdr_TLAST_i   (hdr_TLAST),
        .hdr_TVALID_i  (hdr_TVALID),
        .hdr_TREADY_o  (hdr_TREADY),
        .sides_TDATA_o (sides_TDATA),
        .sides_TKEEP_o (sides_TKEEP),
        .sides_TLAST_o (sides_TLAST),
        .sides_TDEST_o (sides_TDEST),
        .sides_TID_o   (sides_TID),
        .sides_TUSER_o (sides_TUSER),
        .sides_TVALID_o(sides_TVALID),
        .sides_TREADY_i(sides_TREADY),
        .err_o         (err)
    );

    // 10-unit clock. Posedges fall at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit, so a hung handshake can never stall the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point. It counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one input flit and waits, with a bound, for it to be accepted.
    // Ready is sampled at the negedge. The task returns 1 unit after the
    // accepting posedge.
    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] keep, input logic last,
                                 output bit ok);
        bit acc;
        ok = 0;
        if (randValid) begin
            hdr_TVALID = 1'b0;
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        hdr_TDATA  = data;
        hdr_TKEEP  = keep;
        hdr_TLAST  = last;
        hdr_TVALID = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            acc = hdr_TREADY;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1;
                break;
            end
        end
        hdr_TVALID = 1'b0;
        if (!ok) checkOutput("hdr_accept_timeout", 128'd0, 128'd1);
    endtask

    // Reference model plus driver for one packet. Error pulses come from the
    // packet rules: one for a bad header (pad set or TLAST on the header),
    // and one if first_last disagrees with whether the packet is a single flit.
    task automatic sendPacket(input logic [15:0] dest, input logic [15:0] id, input logic [7:0] user,
                              input logic fl, input logic [22:0] pad, input logic hdrLast,
                              input int n, input logic [63:0] base, input bit randData);
        flit_t       e;
        bit          ok;
        logic [63:0] d;
        logic [7:0]  k;
        if (pad != 23'd0 || hdrLast) expErr++;
        if (fl != (n == 1)) expErr++;
        applyStimulus({pad, fl, dest, id, user}, 8'($urandom), hdrLast, ok);
        if (!ok) return;
        inData = 1;
        for (int i = 0; i < n; i++) begin
            d = randData ? {$urandom, $urandom} : base + 64'(i);
            k = randData ? 8'($urandom) : 8'hFF;
            applyStimulus(d, k, (i == n - 1), ok);
            if (ok) begin
                e.data = d;
                e.keep = k;
                e.last = (i == n - 1);
                e.dest = dest;
                e.id   = id;
                e.user = user;
                expQ.push_back(e);
            end
        end
        inData = 0;
    endtask

    // Waits, with a bound, until every expected flit has been delivered.
    task automatic waitDrain();
        for (int i = 0; i < 3000 && expQ.size() != 0; i++) @(posedge clk);
        checkOutput("drain_queue_empty", 128'(expQ.size()), 128'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output-side ready driver. Modes: 0 always ready, 1 random (about 75%),
    // 2 repeating pattern 1,0,0, 3 held low.
    always @(posedge clk) begin
        #1;
        case (rdyMode)
            0: sides_TREADY = 1'b1;
            1: sides_TREADY = ($urandom_range(0, 3) != 0);
            2: begin
                sides_TREADY = ((patIdx % 3) == 0);
                patIdx++;
            end
            default: sides_TREADY = 1'b0;
        endcase
    end

    // Output monitor. It pops the expected queue on each output handshake.
    // It checks that a stalled flit is still valid and unchanged one cycle
    // later. It counts err pulses, one per high cycle.
    always @(negedge clk) begin
        curOut = {sides_TDATA, sides_TKEEP, sides_TLAST, sides_TDEST, sides_TID, sides_TUSER};
        if (!rst_n) begin
            stallPrev = 0;
        end else begin
            if (err) errSeen++;
            if (stallPrev) begin
                checkOutput("stall_hold", {sides_TVALID, curOut}, {1'b1, heldOut});
            end
            if (sides_TVALID && sides_TREADY) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output_flit", 128'd1, 128'd0);
                end else begin
                    flit_t e;
                    e = expQ.pop_front();
                    checkOutput("out_data", 128'(sides_TDATA), 128'(e.data));
                    checkOutput("out_keep", 128'(sides_TKEEP), 128'(e.keep));
                    checkOutput("out_last", 128'(sides_TLAST), 128'(e.last));
                    checkOutput("out_sides", 128'({sides_TDEST, sides_TID, sides_TUSER}),
                                128'({e.dest, e.id, e.user}));
                end
            end
            stallPrev = sides_TVALID && !sides_TREADY;
            heldOut   = curOut;
        end
    end

    // While a packet's data flits are streaming, the input should be ready
    // exactly when fewer than two flits are buffered. The count of
    // accepted-but-undelivered flits is the expected queue depth.
    always @(posedge clk) begin
        #2;
        if (checkReadyEn && inData && rst_n) begin
            checkOutput("hdr_ready_vs_fill", 128'(hdr_TREADY), 128'(expQ.size() < 2));
        end
    end

    initial begin
        int  eBase;
        int  xBase;
        bit  ok;
        int  n;
        logic        fl;
        logic [22:0] pad;
        logic        hl;

        rst_n        = 1'b0;
        hdr_TDATA    = '0;
        hdr_TKEEP    = '0;
        hdr_TLAST    = 1'b0;
        hdr_TVALID   = 1'b0;
        sides_TREADY = 1'b1;

        // Reset state and ready release timing.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hdr_ready", 128'(hdr_TREADY), 128'd0);
        checkOutput("reset_valid", 128'(sides_TVALID), 128'd0);
        checkOutput("reset_err", 128'(err), 128'd0);
        checkOutput("reset_data", 128'({sides_TDATA, sides_TDEST, sides_TID, sides_TUSER}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_first_edge", 128'(hdr_TREADY), 128'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_first_edge", 128'(hdr_TREADY), 128'd1);

        // Single-flit packet whose header has first_last set: no error, and
        // the flit appears one cycle after acceptance.
        $display("[TB] single flit packet");
        rdyMode = 0;
        eBase = errSeen;
        sendPacket(16'hABCD, 16'h1234, 8'h56, 1'b1, 23'd0, 1'b0, 1, 64'h1111, 0);
        checkOutput("t1_latency_valid", 128'(sides_TVALID), 128'd1);
        checkOutput("t1_data", 128'(sides_TDATA), 128'h1111);
        checkOutput("t1_keep_last", 128'({sides_TKEEP, sides_TLAST}), 128'({8'hFF, 1'b1}));
        checkOutput("t1_sides", 128'({sides_TDEST, sides_TID, sides_TUSER}), 128'({16'hABCD, 16'h1234, 8'h56}));
        waitDrain();
        checkOutput("t1_err_count", 128'(errSeen - eBase), 128'd0);

        // Four data flits against a stalling consumer, checking ready versus fill.
        $display("[TB] stalled consumer");
        patIdx = 0;
        rdyMode = 2;
        checkReadyEn = 1;
        eBase = errSeen;
        sendPacket(16'hABCD, 16'h1234, 8'h56, 1'b0, 23'd0, 1'b0, 4, 64'h2000, 0);
        waitDrain();
        checkReadyEn = 0;
        checkOutput("t2_err_count", 128'(errSeen - eBase), 128'd0);

        // Back-to-back packets while output is blocked. The second header is
        // latched while the first packet's flits are still queued. Its
        // single flit follows a header with first_last clear, so one err.
        $display("[TB] back to back packets");
        rdyMode = 3;
        eBase = errSeen;
        fork
            begin
                repeat (3) @(posedge clk);
                rdyMode = 0;
            end
        join_none
        sendPacket(16'hABCD, 16'h1234, 8'h56, 1'b0, 23'd0, 1'b0, 2, 64'h3000, 0);
        sendPacket(16'h5555, 16'h0001, 8'h01, 1'b0, 23'd0, 1'b0, 1, 64'h3100, 0);
        waitDrain();
        checkOutput("t3_err_count", 128'(errSeen - eBase), 128'd1);

        // Error cases: pad set; first_last mismatch; TLAST on the header;
        // pad and header TLAST together giving one pulse.
        $display("[TB] error cases");
        rdyMode = 0;
        eBase = errSeen;
        sendPacket(16'hABCD, 16'h1234, 8'h56, 1'b0, 23'h40, 1'b0, 2, 64'h4000, 0);
        waitDrain();
        checkOutput("t4_pad_err", 128'(errSeen - eBase), 128'd1);
        eBase = errSeen;
        sendPacket(16'hABCD, 16'h1234, 8'h56, 1'b1, 23'd0, 1'b0, 3, 64'h4100, 0);
        waitDrain();
        checkOutput("t4_first_last_err", 128'(errSeen - eBase), 128'd1);
        eBase = errSeen;
        sendPacket(16'h0F0F, 16'hF0F0, 8'hAA, 1'b0, 23'd0, 1'b1, 2, 64'h4200, 0);
        waitDrain();
        checkOutput("t4_hdr_last_err", 128'(errSeen - eBase), 128'd1);
        eBase = errSeen;
        sendPacket(16'h0F0F, 16'hF0F0, 8'hAA, 1'b0, 23'h1, 1'b1, 2, 64'h4300, 0);
        waitDrain();
        checkOutput("t4_combined_single_pulse", 128'(errSeen - eBase), 128'd1);

        // Reset in the middle of a packet with one flit still buffered.
        $display("[TB] reset mid packet");
        rdyMode = 3;
        applyStimulus(64'h0000_00AB_CD12_3456, 8'h00, 1'b0, ok);
        applyStimulus(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, ok);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("t5_valid_async_clear", 128'(sides_TVALID), 128'd0);
        checkOutput("t5_ready_in_reset", 128'(hdr_TREADY), 128'd0);
        checkOutput("t5_data_cleared", 128'({sides_TDATA, sides_TDEST, sides_TID, sides_TUSER}), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("t5_ready_before_edge", 128'(hdr_TREADY), 128'd0);
        @(posedge clk);
        #1;
        rdyMode = 0;
        eBase = errSeen;
        sendPacket(16'hABCD, 16'h1234, 8'h56, 1'b0, 23'd0, 1'b0, 2, 64'h5000, 0);
        waitDrain();
        checkOutput("t5_err_count", 128'(errSeen - eBase), 128'd0);

        // Random traffic on both sides, with occasional malformed headers.
        $display("[TB] random packets");
        rdyMode   = 1;
        randValid = 1;
        eBase = errSeen;
        xBase = expErr;
        for (int p = 0; p < 1000; p++) begin
            n   = $urandom_range(1, 16);
            fl  = (n == 1);
            if ($urandom_range(0, 19) == 0) fl = ~fl;
            pad = 23'd0;
            if ($urandom_range(0, 24) == 0) pad = 23'($urandom) | 23'h1;
            hl  = ($urandom_range(0, 29) == 0);
            sendPacket(16'($urandom), 16'($urandom), 8'($urandom), fl, pad, hl, n, 64'd0, 1);
        end
        randValid = 0;
        waitDrain();
        checkOutput("rand_err_count", 128'(errSeen - eBase), 128'(expErr - xBase));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
